// File: rtl/ram_pkg.sv
// Shared types and default geometry for the ram_bank slice.
package ram_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_ADDR_W = 3;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

endpackage

// File: rtl/ram_bank_if.sv
// Access bus for ram_bank: write/read request side and registered read return.
interface ram_bank_if
   import ram_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W
);

   logic [WIDTH-1:0]  in;
   logic              load;
   logic              rd;
   logic [ADDR_W-1:0] address;
   logic              clear;
   logic [WIDTH-1:0]  out;
   logic              out_valid;
   logic              ready;

   modport master (
      output in, load, rd, address, clear,
      input  out, out_valid, ready
   );

   modport slave (
      input  in, load, rd, address, clear,
      output out, out_valid, ready
   );

endinterface

// File: rtl/ram_bank_array.sv
// Storage for ram_bank: one synchronous write port, one asynchronous read port.
module ram_bank_array
   import ram_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ram_bank.sv
// Word-addressed RAM bank with a self-sequenced zero-fill and a registered,
// write-first read port.
module ram_bank
   import ram_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int INIT_CLEAR = 1
) (
   input  logic       CLK,
   input  logic       RST_N,
   ram_bank_if.slave  bus
);

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [WIDTH-1:0]  out_p1;
   logic              vld_p1;

   logic              idle;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic [WIDTH-1:0]  rdata;
   logic [WIDTH-1:0]  rd_word_p0;

   assign idle = (state == IDLE);

   // Writes are suppressed while reset is sampled so retained contents survive it.
   always_comb begin
      we    = 1'b0;
      waddr = bus.address;
      wdata = bus.in;
      if (RST_N) begin
         if (!idle) begin
            we    = 1'b1;
            waddr = cnt;
            wdata = '0;
         end else if (bus.load) begin
            we = 1'b1;
         end
      end
   end

   ram_bank_array #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (CLK),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (bus.address),
      .rdata (rdata)
   );

   // Read and write share one address, so a concurrent load always bypasses.
   assign rd_word_p0 = bus.load ? bus.in : rdata;

   // ---- stage p0 -> p1: control state and registered read data ----
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state  <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
         cnt    <= '0;
         out_p1 <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= 1'b0;
         case (state)
            CLEAR: begin
               if (bus.clear) begin
                  cnt <= '0;
               end else if (cnt == '1) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IDLE: begin
               if (bus.rd) begin
                  out_p1 <= rd_word_p0;
                  vld_p1 <= 1'b1;
               end
               if (bus.clear) begin
                  cnt   <= '0;
                  state <= CLEAR;
               end
            end
            default: begin
               state <= CLEAR;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.out       = out_p1;
   assign bus.out_valid = vld_p1;
   assign bus.ready     = idle;

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: a zero-filling 16x8 bank checked every cycle
// against a behavioural model, and a retaining 32x64 bank checked directly.
module tb_ram_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_n;
   logic rst_b_n;

   ram_bank_if #(.WIDTH(16), .ADDR_W(3)) bus_a ();
   ram_bank_if #(.WIDTH(32), .ADDR_W(6)) bus_b ();

   ram_bank #(.WIDTH(16), .ADDR_W(3), .INIT_CLEAR(1)) dut_a (
      .CLK   (clk),
      .RST_N (rst_a_n),
      .bus   (bus_a)
   );

   ram_bank #(.WIDTH(32), .ADDR_W(6), .INIT_CLEAR(0)) dut_b (
      .CLK   (clk),
      .RST_N (rst_b_n),
      .bus   (bus_b)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Behavioural model of bank A: contents, words still to be zeroed, read result.
   logic [15:0] m_mem [8];
   int          fill_left = 0;
   logic [15:0] m_out     = '0;
   logic        m_vld     = 1'b0;
   bit          m_live    = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_a_n) begin
            m_live    = 1'b1;
            fill_left = 8;
            m_out     = '0;
            m_vld     = 1'b0;
         end else if (m_live) begin
            m_vld = 1'b0;
            if (fill_left > 0) begin
               m_mem[8 - fill_left] = '0;
               fill_left = bus_a.clear ? 8 : fill_left - 1;
            end else begin
               if (bus_a.load) m_mem[bus_a.address] = bus_a.in;
               if (bus_a.rd) begin
                  m_out = m_mem[bus_a.address];
                  m_vld = 1'b1;
               end
               if (bus_a.clear) fill_left = 8;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (m_live) begin
            check("model_out", {16'h0, bus_a.out}, {16'h0, m_out});
            check("model_out_valid", {31'h0, bus_a.out_valid}, {31'h0, m_vld});
            check("model_ready", {31'h0, bus_a.ready}, {31'h0, fill_left == 0});
         end
      end
   end

   task automatic a_write(input logic [2:0] addr, input logic [15:0] data);
      bus_a.load    = 1'b1;
      bus_a.address = addr;
      bus_a.in      = data;
      @(negedge clk);
      bus_a.load = 1'b0;
   endtask

   task automatic a_read(input logic [2:0] addr, input logic [15:0] exp, input string name);
      bus_a.rd      = 1'b1;
      bus_a.address = addr;
      @(negedge clk);
      bus_a.rd = 1'b0;
      check(name, {16'h0, bus_a.out}, {16'h0, exp});
      check({name, "_vld"}, {31'h0, bus_a.out_valid}, 32'd1);
   endtask

   task automatic b_write(input logic [5:0] addr, input logic [31:0] data);
      bus_b.load    = 1'b1;
      bus_b.address = addr;
      bus_b.in      = data;
      @(negedge clk);
      bus_b.load = 1'b0;
   endtask

   task automatic b_read(input logic [5:0] addr, input logic [31:0] exp, input string name);
      bus_b.rd      = 1'b1;
      bus_b.address = addr;
      @(negedge clk);
      bus_b.rd = 1'b0;
      check(name, bus_b.out, exp);
      check({name, "_vld"}, {31'h0, bus_b.out_valid}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      bus_a.in = '0; bus_a.load = 1'b0; bus_a.rd = 1'b0; bus_a.address = '0; bus_a.clear = 1'b0;
      bus_b.in = '0; bus_b.load = 1'b0; bus_b.rd = 1'b0; bus_b.address = '0; bus_b.clear = 1'b0;

      // Bank A: reset, then initial fill of 8 words
      repeat (2) @(negedge clk);
      check("a_rst_ready", {31'h0, bus_a.ready}, 32'd0);
      check("a_rst_out", {16'h0, bus_a.out}, 32'h0);
      check("a_rst_vld", {31'h0, bus_a.out_valid}, 32'd0);
      rst_a_n = 1'b1;
      n = 0;
      while (!bus_a.ready && n < 20) begin n++; @(negedge clk); end
      check("a_init_fill_len", n, 32'd8);
      for (int a = 0; a < 8; a++) a_read(3'(a), 16'h0000, "a_init_read");

      // Write then read, single valid pulse, held output
      a_write(3'd5, 16'hBEEF);
      a_read(3'd5, 16'hBEEF, "a_wr_rd");
      @(negedge clk);
      check("a_vld_pulse", {31'h0, bus_a.out_valid}, 32'd0);
      check("a_out_hold", {16'h0, bus_a.out}, 32'h0000BEEF);

      // Read during write of the same word returns the new data
      bus_a.load = 1'b1; bus_a.rd = 1'b1; bus_a.address = 3'd2; bus_a.in = 16'h1234;
      @(negedge clk);
      bus_a.load = 1'b0; bus_a.rd = 1'b0;
      check("a_rdw", {16'h0, bus_a.out}, 32'h00001234);
      check("a_rdw_vld", {31'h0, bus_a.out_valid}, 32'd1);

      // Clear: fill all ones, pulse clear, a load during the fill is dropped
      for (int a = 0; a < 8; a++) a_write(3'(a), 16'hFFFF);
      a_read(3'd1, 16'hFFFF, "a_pre_clear");
      bus_a.clear = 1'b1;
      @(negedge clk);
      bus_a.clear = 1'b0; bus_a.load = 1'b1; bus_a.rd = 1'b1; bus_a.address = 3'd1; bus_a.in = 16'hAAAA;
      n = 0;
      while (!bus_a.ready && n < 20) begin
         n++; @(negedge clk);
         bus_a.load = 1'b0; bus_a.rd = 1'b0;
      end
      check("a_clear_len", n, 32'd8);
      a_read(3'd1, 16'h0000, "a_clear_drop");
      a_read(3'd6, 16'h0000, "a_clear_word6");

      // Clear re-requested mid-fill restarts the counter: 4 + 8 cycles low
      bus_a.clear = 1'b1;
      @(negedge clk);
      bus_a.clear = 1'b0;
      n = 0;
      while (!bus_a.ready && n < 40) begin
         n++; @(negedge clk);
         bus_a.clear = (n == 3);
      end
      bus_a.clear = 1'b0;
      check("a_clear_restart_len", n, 32'd12);

      // Clear together with load: load lands, then the fill erases it
      bus_a.clear = 1'b1; bus_a.load = 1'b1; bus_a.rd = 1'b1; bus_a.address = 3'd4; bus_a.in = 16'h4444;
      @(negedge clk);
      bus_a.clear = 1'b0; bus_a.load = 1'b0; bus_a.rd = 1'b0;
      check("a_clear_load_rd", {16'h0, bus_a.out}, 32'h00004444);
      n = 0;
      while (!bus_a.ready && n < 20) begin n++; @(negedge clk); end
      check("a_clear_load_len", n, 32'd8);
      a_read(3'd4, 16'h0000, "a_clear_load_erased");

      // Reset during a fill restarts it from word 0
      a_write(3'd7, 16'h7777);
      a_write(3'd6, 16'h5A5A);
      a_read(3'd6, 16'h5A5A, "a_pre_midrst");
      bus_a.clear = 1'b1;
      @(negedge clk);
      bus_a.clear = 1'b0;
      repeat (3) @(negedge clk);
      rst_a_n = 1'b0;
      @(negedge clk);
      check("a_midrst_out", {16'h0, bus_a.out}, 32'h0);
      check("a_midrst_ready", {31'h0, bus_a.ready}, 32'd0);
      rst_a_n = 1'b1;
      n = 0;
      while (!bus_a.ready && n < 20) begin n++; @(negedge clk); end
      check("a_midrst_fill_len", n, 32'd8);
      a_read(3'd7, 16'h0000, "a_midrst_word7");
      a_read(3'd6, 16'h0000, "a_midrst_word6");

      // Bank B: no fill, contents retained across reset
      check("b_rst_ready", {31'h0, bus_b.ready}, 32'd1);
      check("b_rst_out", bus_b.out, 32'h0);
      rst_b_n = 1'b1;
      @(negedge clk);
      check("b_ready_after_rst", {31'h0, bus_b.ready}, 32'd1);
      b_write(6'd42, 32'hDEADBEEF);
      b_write(6'd63, 32'h12345678);
      b_read(6'd42, 32'hDEADBEEF, "b_wr_rd");
      rst_b_n = 1'b0;
      repeat (2) @(negedge clk);
      check("b_rst2_out", bus_b.out, 32'h0);
      check("b_rst2_vld", {31'h0, bus_b.out_valid}, 32'd0);
      check("b_rst2_ready", {31'h0, bus_b.ready}, 32'd1);
      rst_b_n = 1'b1;
      b_read(6'd42, 32'hDEADBEEF, "b_retain42");
      b_read(6'd63, 32'h12345678, "b_retain63");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ram_bank.md
RAM_BANK -- requirements
Module: ram_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter INIT_CLEAR, default 1; 1 = zero-fill the array after reset, 0 = skip the fill.
REQ-004 The block SHALL have port CLK, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST_N, input, 1, reset, synchronous and active-low.
REQ-006 The block SHALL have port in, input, WIDTH, write data.
REQ-007 The block SHALL have port load, input, 1, write enable for the word at address.
REQ-008 The block SHALL have port rd, input, 1, read request for the word at address.
REQ-009 The block SHALL have port address, input, ADDR_W, word select for both read and write.
REQ-010 The block SHALL have port clear, input, 1, single-cycle request to re-run the zero-fill.
REQ-011 The block SHALL have port out, output, WIDTH, registered read data.
REQ-012 The block SHALL have port out_valid, output, 1, one-cycle pulse marking new data on out.
REQ-013 The block SHALL have port ready, output, 1, high when load and rd are accepted.

Function
REQ-014 The block SHALL implement FSM states CLEAR and IDLE.
REQ-015 CLEAR SHALL write zero to one word per cycle, using an internal ADDR_W-bit counter that starts at 0.
REQ-016 CLEAR SHALL go to IDLE in the cycle it writes word DEPTH-1, so a full fill takes exactly DEPTH cycles.
REQ-017 The fill counter SHALL wrap from DEPTH-1 to 0, never going outside the range.
REQ-018 ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, load=1 SHALL write in to word[address] at the clock edge.
REQ-020 In IDLE, rd=1 SHALL, at the next edge, update out to word[address] and set out_valid=1 for exactly one cycle.
REQ-021 Read latency SHALL be 1 cycle.
REQ-022 When rd=0, out SHALL hold its previous value and out_valid SHALL be 0.
REQ-023 Read and write of the same address in the same cycle SHALL return the new in value on out (write-first).
REQ-024 Read and write of different addresses in the same cycle SHALL both complete.
REQ-025 In CLEAR, load and rd SHALL be ignored: no write, out unchanged, out_valid=0; no queuing.
REQ-026 clear=1 in IDLE SHALL enter CLEAR at the next edge with the counter at 0, independent of INIT_CLEAR.
REQ-027 If clear and load are both 1 in IDLE, the load SHALL be performed and then erased by the fill.
REQ-028 clear=1 while already in CLEAR SHALL restart the counter at 0.

Reset
REQ-029 While RST_N=0 at a clock edge, the block SHALL set out=0, out_valid=0 and counter=0.
REQ-030 While RST_N=0 at a clock edge, the state SHALL become CLEAR if INIT_CLEAR=1, else IDLE.
REQ-031 Reset SHALL NOT clear array contents directly; with INIT_CLEAR=0, contents are retained across reset.
REQ-032 Reset asserted in the middle of a fill SHALL restart the fill from word 0.
REQ-033 The outputs SHALL have defined values from the first edge at which RST_N=0 is sampled.

Structure
REQ-034 Package ram_pkg SHALL hold the state type {CLEAR, IDLE} and the default WIDTH and ADDR_W constants.
REQ-035 The storage array SHALL be a single sub-module, ram_bank_array: parameterised WIDTH/ADDR_W, one synchronous write port and one asynchronous read port.
REQ-036 The FSM, fill counter, write-first bypass and out register SHALL reside in ram_bank.

Verification
REQ-037 Reset test: INIT_CLEAR=1, WIDTH=16, ADDR_W=3, RST_N low 2 cycles then high -> ready=0 for exactly 8 cycles, then 1; a read of each address returns 0x0000.
REQ-038 Write/read test: write 0xBEEF to address 5, then rd at 5 the next cycle -> out=0xBEEF with one out_valid pulse one cycle later.
REQ-039 Read-during-write test: load=1, rd=1, address 2, in=0x1234, word previously 0x0000 -> out=0x1234.
REQ-040 Clear test: all words written to 0xFFFF, pulse clear -> ready low 8 cycles; a load of 0xAAAA to address 1 during this period is dropped; address 1 then reads 0x0000.
REQ-041 Reset-mid-fill test: RST_N low at fill cycle 4 -> fill restarts and ready rises 8 cycles after RST_N goes high.
REQ-042 Retain test: INIT_CLEAR=0, WIDTH=32, ADDR_W=6 -> ready=1 right after reset; a word written before reset still reads back after reset.
